// File: rtl/twenty_bit_serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: default width, FSM state
// encodings, counter width and the signed-overflow helper.
package twenty_bit_serial_subtractor_pkg;

    localparam int SUB_WIDTH = 20;
    localparam int CNT_W     = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Two's complement overflow of a - b: operands differ in sign and the
    // result sign differs from the minuend.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/twenty_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/twenty_bit_serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per cycle, LSB first,
// using a single full_subtractor and a three-state control FSM. All outputs
// are registered and hold until the next operation finishes.
module twenty_bit_serial_subtractor
    import twenty_bit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Bin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d;
    logic             fs_bout;
    logic             accept;
    logic [WIDTH-1:0] final_res;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Result register contents after the current bit is shifted in; on the
    // last SHIFT cycle this is the complete difference.
    assign final_res = {fs_d, res_q[WIDTH-1:1]};

    // start only matters when no operation is running.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and datapath logic for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = final_res;
                brw_d  = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = final_res;
                    bout_d  = fs_bout;
                    ovf_d   = sub_overflow(a_msb_q, b_msb_q, final_res[WIDTH-1]);
                    zero_d  = (final_res == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Accepted start overrides the IDLE/DONE fall-through: load operands
        // and the borrow, and begin shifting on the next edge.
        if (accept) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
            cnt_d   = '0;
            a_sh_d  = A;
            b_sh_d  = B;
            brw_d   = Bin;
            a_msb_d = A[WIDTH-1];
            b_msb_d = B[WIDTH-1];
        end
    end

    // State register with synchronous active-low reset that clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Ovf  = ovf_q;
    assign Zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
